// File: rtl/four_step_commutator_pkg.sv
// Shared types and helpers for the four-step matrix-converter commutator.
package commut_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN_ON,
    ST_ON,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4,
    ST_OFF_WAIT
  } state_e;

  // Which dwell a state waits for; the cycle counts are per-instance parameters.
  typedef enum logic [1:0] {
    DW_NONE,
    DW_ON,
    DW_OFF
  } dwell_e;

  localparam int GATE_POS = 0;
  localparam int GATE_NEG = 1;

  // Bit position of a device in the gate vector; phase is 1-based.
  function automatic int gate_idx(input int phase, input int dev);
    return 2 * (phase - 1) + dev;
  endfunction

  // Turn-on style steps (a device gets added) wait TON, turn-off style steps wait TOFF.
  function automatic dwell_e dwell_of(input state_e st);
    case (st)
      ST_TURN_ON, ST_S2, ST_S4:   return DW_ON;
      ST_S1, ST_S3, ST_OFF_WAIT:  return DW_OFF;
      default:                    return DW_NONE;
    endcase
  endfunction

endpackage

// File: rtl/four_step_commutator_if.sv
// Modulator / sense-front-end side of one commutator output leg.
interface four_step_commutator_if #(
  parameter int NPH = 3,
  parameter int PW  = $clog2(NPH + 1)
);
  logic [PW-1:0]    req_phase;
  logic             cur_sign;
  logic             sign_valid;
  logic [2*NPH-1:0] gate;
  logic [PW-1:0]    active;
  logic             busy;
  logic             err_req;

  modport master (
    output req_phase, cur_sign, sign_valid,
    input  gate, active, busy, err_req
  );

  modport slave (
    input  req_phase, cur_sign, sign_valid,
    output gate, active, busy, err_req
  );
endinterface

// File: rtl/four_step_commutator_dwell_timer.sv
// Dwell counter: cleared on state entry, done while in the last cycle of the dwell.
module dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] dwell,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A zero dwell means the current state is untimed; done never fires there.
  assign done = (dwell != '0) && (cnt_q == dwell - 1'b1);

  // Next count: clear on load, advance until the final cycle, then hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (dwell != '0 && !done)
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/four_step_commutator.sv
// Current-sign based four-step commutation controller for one output leg.
// Inputs are registered once, then the FSM acts; every output is a flop, so a
// request sampled at edge t changes the gates after edge t+1.
module four_step_commutator
  import commut_pkg::*;
#(
  parameter int NPH      = 3,
  parameter int TOFF_CYC = 9,
  parameter int TON_CYC  = 1,
  parameter int CNT_W    = 8,
  parameter int PW       = $clog2(NPH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  four_step_commutator_if.slave bus
);
  localparam logic [PW-1:0]    NPH_P  = PW'(NPH);
  localparam logic [CNT_W-1:0] TON_W  = CNT_W'(TON_CYC);
  localparam logic [CNT_W-1:0] TOFF_W = CNT_W'(TOFF_CYC);

  // One-hot mask of a single device of phase p (p = 0 gives no bits).
  function automatic logic [2*NPH-1:0] dev_mask(input logic [PW-1:0] p, input int dev);
    logic [2*NPH-1:0] m;
    m = '0;
    for (int k = 1; k <= NPH; k++)
      if (p == PW'(k)) m[gate_idx(k, dev)] = 1'b1;
    return m;
  endfunction

  // Gate pattern for a state; a = source / connected phase, b = destination.
  function automatic logic [2*NPH-1:0] gate_of(input state_e st, input logic [PW-1:0] a,
                                               input logic [PW-1:0] b, input logic s);
    int c, n;
    c = s ? GATE_POS : GATE_NEG;
    n = s ? GATE_NEG : GATE_POS;
    case (st)
      ST_TURN_ON: return dev_mask(b, GATE_POS) | dev_mask(b, GATE_NEG);
      ST_ON:      return dev_mask(a, GATE_POS) | dev_mask(a, GATE_NEG);
      ST_S1:      return dev_mask(a, c);
      ST_S2:      return dev_mask(a, c) | dev_mask(b, c);
      ST_S3:      return dev_mask(b, c);
      ST_S4:      return dev_mask(b, c) | dev_mask(b, n);
      default:    return '0;
    endcase
  endfunction

  logic [PW-1:0]    req_q;
  logic             sign_in_q, valid_in_q;
  state_e           state_q, state_d;
  logic [PW-1:0]    src_q, src_d, dst_q, dst_d;
  logic             sgn_q, sgn_d;
  logic [2*NPH-1:0] gate_q, gate_d;
  logic [PW-1:0]    active_q, active_d;
  logic             busy_q, busy_d, err_q, err_d;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_dwell;

  // Sample the request and sign inputs once per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= '0;
      sign_in_q  <= 1'b0;
      valid_in_q <= 1'b0;
    end else begin
      req_q      <= bus.req_phase;
      sign_in_q  <= bus.cur_sign;
      valid_in_q <= bus.sign_valid;
    end
  end

  // Dwell length of the state we are in; counter restarts on every state change.
  always_comb begin
    case (dwell_of(state_q))
      DW_ON:   tmr_dwell = TON_W;
      DW_OFF:  tmr_dwell = TOFF_W;
      default: tmr_dwell = '0;
    endcase
  end

  assign tmr_load = (state_d != state_q);

  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .dwell (tmr_dwell),
    .done  (tmr_done)
  );

  // Next-state logic; requests are only looked at from IDLE and ON.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    sgn_d   = sgn_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_q > NPH_P) begin
          err_d = 1'b1;
        end else if (req_q != '0) begin
          dst_d   = req_q;
          state_d = ST_TURN_ON;
        end
      end
      ST_TURN_ON: begin
        if (tmr_done) begin
          src_d   = dst_q;
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (req_q > NPH_P) begin
          err_d = 1'b1;
        end else if (req_q == '0) begin
          dst_d   = '0;
          state_d = ST_OFF_WAIT;
        end else if (req_q != src_q) begin
          dst_d = req_q;
          if (valid_in_q) begin
            sgn_d   = sign_in_q;
            state_d = ST_S1;
          end else begin
            // Sign unknown: fall back to break-before-make.
            state_d = ST_OFF_WAIT;
          end
        end
      end
      ST_S1: if (tmr_done) state_d = ST_S2;
      ST_S2: if (tmr_done) state_d = ST_S3;
      ST_S3: if (tmr_done) state_d = ST_S4;
      ST_S4: begin
        if (tmr_done) begin
          src_d   = dst_q;
          state_d = ST_ON;
        end
      end
      ST_OFF_WAIT: begin
        if (tmr_done) begin
          if (dst_q == '0) begin
            src_d   = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_TURN_ON;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    gate_d   = gate_of(state_d, src_d, dst_d, sgn_d);
    active_d = (state_d == ST_ON) ? src_d : '0;
    busy_d   = !(state_d == ST_IDLE || state_d == ST_ON);
  end

  // State and output registers; reset forces every gate off at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      sgn_q    <= 1'b0;
      gate_q   <= '0;
      active_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      sgn_q    <= sgn_d;
      gate_q   <= gate_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign bus.gate    = gate_q;
  assign bus.active  = active_q;
  assign bus.busy    = busy_q;
  assign bus.err_req = err_q;
endmodule

// File: tb/tb_four_step_commutator.sv
// Directed checks on a 4-phase leg with default dwells, then a random stress
// run on a short-dwell leg against a queue-based expected-gate model.
module tb_four_step_commutator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  four_step_commutator_if #(.NPH(4)) ifa ();
  four_step_commutator_if #(.NPH(4)) ifb ();

  four_step_commutator #(.NPH(4), .TOFF_CYC(9), .TON_CYC(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  four_step_commutator #(.NPH(4), .TOFF_CYC(3), .TON_CYC(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  // Safety rules on a 4-phase gate word.
  function automatic bit inv_ok(input logic [7:0] g, input logic busy, input logic [2:0] act);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (g[2*i] || g[2*i+1]) n++;
      for (int j = 0; j < 4; j++)
        if (i != j && g[2*i] && g[2*j+1]) return 1'b0;
    end
    if (!busy && act == 3'd0 && g != 8'h00) return 1'b0;
    return n <= 2;
  endfunction

  assert property (@(negedge clk) disable iff (rst) inv_ok(ifa.gate, ifa.busy, ifa.active))
    else begin n_bad++; $error("FAIL inv_a gate=%h", ifa.gate); end
  assert property (@(negedge clk) disable iff (rst) inv_ok(ifb.gate, ifb.busy, ifb.active))
    else begin n_bad++; $error("FAIL inv_b gate=%h", ifb.gate); end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin n_bad++; $error("FAIL %s: got %0h want %0h", tag, obs, exp); end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input string tag, input logic [7:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, 32'(ifa.gate), 32'(word));
      tick();
    end
  endtask

  task automatic settle_a(input logic [2:0] ph, input int bound);
    for (int i = 0; i < bound && !(ifa.busy == 1'b0 && ifa.active == ph); i++) tick();
    chk("settle", 32'(ifa.active), 32'(ph));
  endtask

  // Stress model state.
  logic [7:0] mq[$];
  int         m_phase;
  bit         m_busy;
  int         n_comm;

  function automatic logic [7:0] bit_of(input int p, input int dev);
    return 8'(1) << (2 * (p - 1) + dev);
  endfunction

  task automatic push_n(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) mq.push_back(w);
  endtask

  initial begin
    logic [2:0] cur_req, prev_req;
    logic       cur_sign, prev_sign, cur_valid, prev_valid;
    logic [7:0] exp_g, both;
    logic       exp_err;
    int         c, nd;

    ifa.req_phase = '0; ifa.cur_sign = 1'b0; ifa.sign_valid = 1'b0;
    ifb.req_phase = '0; ifb.cur_sign = 1'b0; ifb.sign_valid = 1'b0;
    repeat (3) tick();
    chk("rst_gate", 32'(ifa.gate), 0);
    chk("rst_active", 32'(ifa.active), 0);
    chk("rst_busy", 32'(ifa.busy), 0);
    chk("rst_err", 32'(ifa.err_req), 0);
    chk("rst_gate_b", 32'(ifb.gate), 0);

    // Power up phase 1.
    rst = 1'b0;
    ifa.req_phase = 3'd1;
    tick();
    tick();
    chk("ton_gate", 32'(ifa.gate), 32'h03);
    chk("ton_busy", 32'(ifa.busy), 1);
    chk("ton_active", 32'(ifa.active), 0);
    tick();
    chk("on1_gate", 32'(ifa.gate), 32'h03);
    chk("on1_active", 32'(ifa.active), 1);
    chk("on1_busy", 32'(ifa.busy), 0);

    // 1 -> 2, positive current.
    ifa.req_phase = 3'd2; ifa.cur_sign = 1'b1; ifa.sign_valid = 1'b1;
    tick();
    chk("lat_p", 32'(ifa.gate), 32'h03);
    tick();
    expect_run("s1p", 8'h01, 9);
    expect_run("s2p", 8'h05, 1);
    expect_run("s3p", 8'h04, 9);
    expect_run("s4p", 8'h0C, 1);
    chk("on2_gate", 32'(ifa.gate), 32'h0C);
    chk("on2_active", 32'(ifa.active), 2);
    chk("on2_busy", 32'(ifa.busy), 0);

    // Back to 1, then 1 -> 2 with negative current; inputs wiggle mid-sequence.
    ifa.req_phase = 3'd1;
    settle_a(3'd1, 40);
    ifa.req_phase = 3'd2; ifa.cur_sign = 1'b0;
    tick();
    chk("lat_n", 32'(ifa.gate), 32'h03);
    tick();
    expect_run("s1n", 8'h02, 4);
    ifa.req_phase = 3'd4; ifa.cur_sign = 1'b1; ifa.sign_valid = 1'b0;
    expect_run("s1n_b", 8'h02, 5);
    ifa.req_phase = 3'd2; ifa.cur_sign = 1'b0; ifa.sign_valid = 1'b1;
    expect_run("s2n", 8'h0A, 1);
    expect_run("s3n", 8'h08, 9);
    expect_run("s4n", 8'h0C, 1);
    chk("on2n_active", 32'(ifa.active), 2);
    tick();
    tick();
    chk("hold2_gate", 32'(ifa.gate), 32'h0C);
    chk("hold2_busy", 32'(ifa.busy), 0);

    // Dead-time path 2 -> 3 with unknown sign.
    ifa.sign_valid = 1'b0; ifa.req_phase = 3'd3;
    tick();
    chk("lat_dt", 32'(ifa.gate), 32'h0C);
    tick();
    expect_run("dt_off", 8'h00, 9);
    expect_run("dt_on", 8'h30, 1);
    chk("on3_gate", 32'(ifa.gate), 32'h30);
    chk("on3_active", 32'(ifa.active), 3);
    chk("on3_busy", 32'(ifa.busy), 0);

    // Out-of-range request while ON phase 1.
    ifa.sign_valid = 1'b1; ifa.cur_sign = 1'b1; ifa.req_phase = 3'd1;
    settle_a(3'd1, 40);
    ifa.req_phase = 3'd5;
    tick();
    ifa.req_phase = 3'd1;
    chk("err_pre", 32'(ifa.err_req), 0);
    tick();
    chk("err_hi", 32'(ifa.err_req), 1);
    chk("err_gate", 32'(ifa.gate), 32'h03);
    chk("err_busy", 32'(ifa.busy), 0);
    tick();
    chk("err_lo", 32'(ifa.err_req), 0);
    chk("err_gate2", 32'(ifa.gate), 32'h03);

    // Reset asserted in S2 of a 1 -> 2 move.
    ifa.req_phase = 3'd2;
    tick();
    tick();
    expect_run("r_s1", 8'h01, 9);
    chk("r_s2", 32'(ifa.gate), 32'h05);
    #2 rst = 1'b1;
    #1;
    chk("arst_gate", 32'(ifa.gate), 0);
    chk("arst_busy", 32'(ifa.busy), 0);
    chk("arst_active", 32'(ifa.active), 0);
    ifa.req_phase = 3'd0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("idle_gate", 32'(ifa.gate), 0);
    chk("idle_busy", 32'(ifa.busy), 0);
    ifa.req_phase = 3'd1;
    tick();
    tick();
    chk("re_ton_gate", 32'(ifa.gate), 32'h03);
    chk("re_ton_busy", 32'(ifa.busy), 1);

    // Random stress on the short-dwell leg.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifa.req_phase = 3'd0;
    prev_req = '0; prev_sign = 1'b0; prev_valid = 1'b0;
    cur_req = '0;
    m_phase = 0; m_busy = 1'b0; n_comm = 0; mq.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if ($urandom_range(0, 5) == 0)
        cur_req = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      cur_sign  = 1'($urandom_range(0, 1));
      cur_valid = ($urandom_range(0, 3) != 0);
      ifb.req_phase = cur_req; ifb.cur_sign = cur_sign; ifb.sign_valid = cur_valid;
      tick();
      // The leg reacts to what it sampled one edge earlier, only when settled.
      exp_err = 1'b0;
      if (!m_busy) begin
        nd = int'(prev_req);
        if (nd > 4) begin
          exp_err = 1'b1;
        end else if (m_phase == 0) begin
          if (nd != 0) begin
            push_n(bit_of(nd, 0) | bit_of(nd, 1), 1);
            m_phase = nd;
          end
        end else if (nd == 0) begin
          push_n(8'h00, 3);
          m_phase = 0;
        end else if (nd != m_phase) begin
          if (prev_valid) begin
            c = prev_sign ? 0 : 1;
            push_n(bit_of(m_phase, c), 3);
            push_n(bit_of(m_phase, c) | bit_of(nd, c), 1);
            push_n(bit_of(nd, c), 3);
            push_n(bit_of(nd, 0) | bit_of(nd, 1), 1);
            n_comm++;
          end else begin
            push_n(8'h00, 3);
            push_n(bit_of(nd, 0) | bit_of(nd, 1), 1);
          end
          m_phase = nd;
        end
      end
      both = (m_phase == 0) ? 8'h00 : (bit_of(m_phase, 0) | bit_of(m_phase, 1));
      if (mq.size() > 0) begin
        exp_g  = mq.pop_front();
        m_busy = 1'b1;
      end else begin
        exp_g  = both;
        m_busy = 1'b0;
      end
      chk("st_gate", 32'(ifb.gate), 32'(exp_g));
      chk("st_busy", 32'(ifb.busy), 32'(m_busy));
      chk("st_active", 32'(ifb.active), m_busy ? 0 : m_phase);
      chk("st_err", 32'(ifb.err_req), 32'(exp_err));
      chk("st_inv", 32'(inv_ok(ifb.gate, ifb.busy, ifb.active)), 1);
      prev_req = cur_req; prev_sign = cur_sign; prev_valid = cur_valid;
    end
    chk("st_comm_seen", 32'(n_comm > 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
